// File: rtl/spart_loader_pkg.sv
// Shared types and constants for the SPART boot loader: FSM states, framing bytes,
// and helpers for sizing the inter-byte timer and accumulating the frame checksum.
package spart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_LO    = 3'd2,
        ST_HI    = 3'd3,
        ST_CSUM  = 3'd4,
        ST_RESP  = 3'd5
    } ldr_state_e;

    localparam logic [7:0] LDR_SYNC = 8'hA5;
    localparam logic [7:0] LDR_ACK  = 8'h06;
    localparam logic [7:0] LDR_NAK  = 8'h15;

    localparam int LDR_TIMEOUT_DEFAULT = 1_000_000;

    // Counter width able to hold the terminal value itself.
    function automatic int ldr_timer_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

    function automatic logic [7:0] ldr_xor_byte(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/spart_loader_timer.sv
// Inter-byte idle counter: counts while enabled, clears on clr or when disabled, and
// flags terminal count once TIMEOUT idle cycles have elapsed.
module loader_timer
    import spart_loader_pkg::*;
#(
    parameter int TIMEOUT = LDR_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int CW = ldr_timer_width(TIMEOUT);
    localparam logic [CW-1:0] TERM = CW'(TIMEOUT);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // Idle-cycle counter; saturates at the terminal value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr || !en) begin
            cnt_r <= '0;
        end else if (cnt_r != TERM) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tc = en && !clr && (cnt_r == TERM);

endmodule

// File: rtl/spart_loader.sv
// spart_loader: parses A5/N/data frames from the SPART receiver and writes 16-bit words to RAM.
// Build option SPART_LOADER_CHECKSUM_EN: expect and verify a trailing XOR checksum byte.
module spart_loader
    import spart_loader_pkg::*;
#(
    parameter int TIMEOUT = LDR_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_full,
    output logic        tx_send,
    output logic [7:0]  tx_data,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    ldr_state_e  state_r, state_n;
    logic [7:0]  idx_r, idx_n;
    logic [7:0]  word_cnt_r, word_cnt_n;
    logic [7:0]  low_r, low_n;
    logic [7:0]  resp_r, resp_n;
    logic        hold_r, hold_n;
    logic        err_r, err_n;
    logic        we_r, we_n;
    logic [7:0]  addr_r, addr_n;
    logic [15:0] wdata_r, wdata_n;
    logic        send_r, send_n;
    logic [7:0]  txd_r, txd_n;
    logic        done_r, done_n;
`ifdef SPART_LOADER_CHECKSUM_EN
    logic [7:0]  csum_r, csum_n;
`endif

    logic active_s;
    logic timeout_s;
    logic last_word_s;

    assign active_s = (state_r == ST_COUNT) || (state_r == ST_LO) ||
                      (state_r == ST_HI)    || (state_r == ST_CSUM);

    // N = 0 encodes 256 words, which the 8-bit wrap of idx + 1 handles naturally.
    assign last_word_s = ((idx_r + 8'd1) == word_cnt_r);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .en  (active_s),
        .clr (rx_valid),
        .tc  (timeout_s)
    );

    // Next-state and next-output logic for the frame parser.
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        word_cnt_n = word_cnt_r;
        low_n      = low_r;
        resp_n     = resp_r;
        hold_n     = hold_r;
        err_n      = err_r;
        we_n       = 1'b0;
        addr_n     = addr_r;
        wdata_n    = wdata_r;
        send_n     = 1'b0;
        txd_n      = txd_r;
        done_n     = 1'b0;
`ifdef SPART_LOADER_CHECKSUM_EN
        csum_n     = csum_r;
`endif

        if (timeout_s) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
            hold_n  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == LDR_SYNC)) begin
                        state_n = ST_COUNT;
                        hold_n  = 1'b1;
                        err_n   = 1'b0;
                        idx_n   = 8'd0;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (rx_valid) begin
                        word_cnt_n = rx_data;
`ifdef SPART_LOADER_CHECKSUM_EN
                        csum_n     = rx_data;
`endif
                        state_n    = ST_LO;
                    end else begin
                        state_n = ST_COUNT;
                    end
                end
                ST_LO: begin
                    if (rx_valid) begin
                        low_n   = rx_data;
`ifdef SPART_LOADER_CHECKSUM_EN
                        csum_n  = ldr_xor_byte(csum_r, rx_data);
`endif
                        state_n = ST_HI;
                    end else begin
                        state_n = ST_LO;
                    end
                end
                ST_HI: begin
                    if (rx_valid) begin
                        we_n    = 1'b1;
                        addr_n  = idx_r;
                        wdata_n = {rx_data, low_r};
                        idx_n   = idx_r + 8'd1;
`ifdef SPART_LOADER_CHECKSUM_EN
                        csum_n  = ldr_xor_byte(csum_r, rx_data);
`endif
                        if (last_word_s) begin
`ifdef SPART_LOADER_CHECKSUM_EN
                            state_n = ST_CSUM;
`else
                            state_n = ST_RESP;
                            resp_n  = LDR_ACK;
`endif
                        end else begin
                            state_n = ST_LO;
                        end
                    end else begin
                        state_n = ST_HI;
                    end
                end
                ST_CSUM: begin
`ifdef SPART_LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        if (rx_data == csum_r) begin
                            resp_n = LDR_ACK;
                        end else begin
                            resp_n = LDR_NAK;
                            err_n  = 1'b1;
                        end
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_CSUM;
                    end
`else
                    state_n = ST_IDLE;
`endif
                end
                ST_RESP: begin
                    // Bytes arriving here are dropped; only the transmit handshake matters.
                    if (!tx_full) begin
                        send_n  = 1'b1;
                        txd_n   = resp_r;
                        hold_n  = 1'b0;
                        done_n  = (resp_r == LDR_ACK);
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_RESP;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    hold_n  = 1'b0;
                end
            endcase
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            idx_r      <= 8'd0;
            word_cnt_r <= 8'd0;
            low_r      <= 8'd0;
            resp_r     <= 8'd0;
            hold_r     <= 1'b0;
            err_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= 8'd0;
            wdata_r    <= 16'd0;
            send_r     <= 1'b0;
            txd_r      <= 8'd0;
            done_r     <= 1'b0;
`ifdef SPART_LOADER_CHECKSUM_EN
            csum_r     <= 8'd0;
`endif
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            word_cnt_r <= word_cnt_n;
            low_r      <= low_n;
            resp_r     <= resp_n;
            hold_r     <= hold_n;
            err_r      <= err_n;
            we_r       <= we_n;
            addr_r     <= addr_n;
            wdata_r    <= wdata_n;
            send_r     <= send_n;
            txd_r      <= txd_n;
            done_r     <= done_n;
`ifdef SPART_LOADER_CHECKSUM_EN
            csum_r     <= csum_n;
`endif
        end
    end

    assign tx_send   = send_r;
    assign tx_data   = txd_r;
    assign mem_we    = we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign cpu_hold  = hold_r;
    assign load_done = done_r;
    assign load_err  = err_r;

endmodule

// File: tb/tb_spart_loader.sv
// Directed self-checking bench for spart_loader (TIMEOUT = 100); checksum scenarios
// are included when SPART_LOADER_CHECKSUM_EN is defined.
module tb_spart_loader;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_full;
    logic        tx_send;
    logic [7:0]  tx_data;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    always #5 clk = ~clk;

    spart_loader #(
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .tx_full   (tx_full),
        .tx_send   (tx_send),
        .tx_data   (tx_data),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    int check_cnt = 0;
    int pass_cnt  = 0;

    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          send_cnt      = 0;
    int          send_full_cnt = 0;
    int          hold_bad_cnt  = 0;
    int          done_cnt      = 0;
    logic [7:0]  last_tx       = 8'h00;
    logic        hold_prev     = 1'b0;

    logic [7:0]  frame_q[$];
`ifdef SPART_LOADER_CHECKSUM_EN
    logic [7:0]  csum_delta = 8'h00;
`endif

    // Passive observer: records RAM writes and transmit events on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (tx_send) begin
            send_cnt++;
            last_tx = tx_data;
            if (tx_full) send_full_cnt++;
            if (cpu_hold || !hold_prev) hold_bad_cnt++;
        end
        if (load_done) done_cnt++;
        hold_prev = cpu_hold;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_body(input int gap);
`ifdef SPART_LOADER_CHECKSUM_EN
        logic [7:0] x = 8'h00;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        frame_q.push_back(x + csum_delta);
`endif
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            idle(gap);
        end
    endtask

    task automatic wait_send(input int base, input int limit);
        int k = 0;
        while (send_cnt == base && k < limit) begin
            idle(1);
            k++;
        end
        check_cnt++;
        if (send_cnt == base) $display("FAIL wait_send: no tx_send within %0d cycles", limit);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_full = 1'b0;
        idle(3);
        check_cnt++;
        if ({tx_send, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== 37'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {tx_send, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err});
        else pass_cnt++;
        rst = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        int bw = wr_addr_q.size();
        int bs = send_cnt;
        int bd = done_cnt;
        int bh = hold_bad_cnt;
        check_cnt++;
        if (cpu_hold !== 1'b0) $display("FAIL basic_hold_pre: got %b expected 0", cpu_hold); else pass_cnt++;
        send_byte(8'hA5);
        check_cnt++;
        if (cpu_hold !== 1'b1) $display("FAIL basic_hold_rise: got %b expected 1", cpu_hold); else pass_cnt++;
        frame_q = {8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        send_body(2);
        wait_send(bs, 50);
        idle(2);
        check_cnt++;
        if (wr_addr_q.size() - bw != 2) $display("FAIL basic_nwrites: got %0d expected 2", wr_addr_q.size() - bw);
        else begin
            pass_cnt++;
            check_cnt++;
            if (wr_addr_q[bw] !== 8'd0 || wr_data_q[bw] !== 16'h1234)
                $display("FAIL basic_word0: got %h@%h expected 1234@00", wr_data_q[bw], wr_addr_q[bw]);
            else pass_cnt++;
            check_cnt++;
            if (wr_addr_q[bw+1] !== 8'd1 || wr_data_q[bw+1] !== 16'hABCD)
                $display("FAIL basic_word1: got %h@%h expected abcd@01", wr_data_q[bw+1], wr_addr_q[bw+1]);
            else pass_cnt++;
        end
        check_cnt++;
        if (last_tx !== 8'h06) $display("FAIL basic_ack: got %h expected 06", last_tx); else pass_cnt++;
        check_cnt++;
        if (done_cnt - bd != 1) $display("FAIL basic_done: got %0d expected 1", done_cnt - bd); else pass_cnt++;
        check_cnt++;
        if (hold_bad_cnt - bh != 0) $display("FAIL basic_hold_at_send: got %0d expected 0", hold_bad_cnt - bh);
        else pass_cnt++;
        check_cnt++;
        if ({cpu_hold, load_err} !== 2'b00) $display("FAIL basic_final: got %b expected 00", {cpu_hold, load_err});
        else pass_cnt++;
    endtask

`ifdef SPART_LOADER_CHECKSUM_EN
    task automatic test_checksum_err();
        int bw = wr_addr_q.size();
        int bs = send_cnt;
        int bd = done_cnt;
        send_byte(8'hA5);
        frame_q = {8'h02, 8'h34, 8'h12, 8'hCD, 8'hAB};
        csum_delta = 8'h01;
        send_body(0);
        csum_delta = 8'h00;
        wait_send(bs, 50);
        idle(2);
        check_cnt++;
        if (wr_addr_q.size() - bw != 2) $display("FAIL csum_nwrites: got %0d expected 2", wr_addr_q.size() - bw);
        else pass_cnt++;
        check_cnt++;
        if (last_tx !== 8'h15) $display("FAIL csum_nak: got %h expected 15", last_tx); else pass_cnt++;
        check_cnt++;
        if (load_err !== 1'b1) $display("FAIL csum_err: got %b expected 1", load_err); else pass_cnt++;
        check_cnt++;
        if (done_cnt - bd != 0) $display("FAIL csum_done: got %0d expected 0", done_cnt - bd); else pass_cnt++;
    endtask
`endif

    task automatic test_timeout();
        int bw = wr_addr_q.size();
        int bs = send_cnt;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h34);
        idle(90);
        check_cnt++;
        if ({cpu_hold, load_err} !== 2'b10) $display("FAIL tmo_early: got %b expected 10", {cpu_hold, load_err});
        else pass_cnt++;
        idle(15);
        check_cnt++;
        if ({cpu_hold, load_err} !== 2'b01) $display("FAIL tmo_fired: got %b expected 01", {cpu_hold, load_err});
        else pass_cnt++;
        check_cnt++;
        if (send_cnt - bs != 0 || wr_addr_q.size() - bw != 0)
            $display("FAIL tmo_quiet: got sends=%0d writes=%0d expected 0 0", send_cnt - bs, wr_addr_q.size() - bw);
        else pass_cnt++;
    endtask

    task automatic test_leading_bytes();
        int bw = wr_addr_q.size();
        int bs = send_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        idle(2);
        check_cnt++;
        if (cpu_hold !== 1'b0) $display("FAIL lead_ignored: got %b expected 0", cpu_hold); else pass_cnt++;
        send_byte(8'hA5);
        check_cnt++;
        if ({cpu_hold, load_err} !== 2'b10) $display("FAIL lead_header: got %b expected 10", {cpu_hold, load_err});
        else pass_cnt++;
        frame_q = {8'h01, 8'h78, 8'h56};
        send_body(0);
        wait_send(bs, 50);
        idle(2);
        check_cnt++;
        if (wr_addr_q.size() - bw != 1 || wr_data_q[wr_data_q.size()-1] !== 16'h5678
            || wr_addr_q[wr_addr_q.size()-1] !== 8'd0)
            $display("FAIL lead_write: got n=%0d last=%h expected n=1 5678@00", wr_addr_q.size() - bw,
                     wr_data_q[wr_data_q.size()-1]);
        else pass_cnt++;
        check_cnt++;
        if (last_tx !== 8'h06) $display("FAIL lead_ack: got %h expected 06", last_tx); else pass_cnt++;
    endtask

    task automatic test_full256();
        int bw = wr_addr_q.size();
        int bs = send_cnt;
        logic [7:0] iv;
        send_byte(8'hA5);
        frame_q = {8'h00};
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            frame_q.push_back(iv);
            frame_q.push_back(iv ^ 8'h5A);
        end
        send_body(0);
        wait_send(bs, 50);
        idle(2);
        check_cnt++;
        if (wr_addr_q.size() - bw != 256) $display("FAIL full_nwrites: got %0d expected 256", wr_addr_q.size() - bw);
        else begin
            pass_cnt++;
            for (int i = 0; i < 256; i++) begin
                iv = 8'(i);
                check_cnt++;
                if (wr_addr_q[bw+i] !== iv || wr_data_q[bw+i] !== {iv ^ 8'h5A, iv})
                    $display("FAIL full_word%0d: got %h@%h expected %h@%h", i, wr_data_q[bw+i], wr_addr_q[bw+i],
                             {iv ^ 8'h5A, iv}, iv);
                else pass_cnt++;
            end
        end
        check_cnt++;
        if (last_tx !== 8'h06) $display("FAIL full_ack: got %h expected 06", last_tx); else pass_cnt++;
    endtask

    task automatic test_tx_full();
        int bs = send_cnt;
        int bf = send_full_cnt;
        int bd = done_cnt;
        tx_full = 1'b1;
        send_byte(8'hA5);
        frame_q = {8'h01, 8'h11, 8'h22};
        send_body(0);
        idle(20);
        check_cnt++;
        if (send_cnt - bs != 0 || cpu_hold !== 1'b1)
            $display("FAIL txfull_blocked: got sends=%0d hold=%b expected 0 1", send_cnt - bs, cpu_hold);
        else pass_cnt++;
        tx_full = 1'b0;
        wait_send(bs, 10);
        idle(2);
        check_cnt++;
        if (send_full_cnt - bf != 0) $display("FAIL txfull_overlap: got %0d expected 0", send_full_cnt - bf);
        else pass_cnt++;
        check_cnt++;
        if (last_tx !== 8'h06 || done_cnt - bd != 1)
            $display("FAIL txfull_ack: got %h done=%0d expected 06 done=1", last_tx, done_cnt - bd);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        int bw;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h34);
        bw = wr_addr_q.size();
        rst = 1'b0;
        #1;
        check_cnt++;
        if ({tx_send, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err} !== 37'd0)
            $display("FAIL midrst_outputs: got %h expected 0",
                     {tx_send, tx_data, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err});
        else pass_cnt++;
        idle(2);
        rst = 1'b1;
        send_byte(8'h12);
        send_byte(8'h56);
        idle(5);
        check_cnt++;
        if (wr_addr_q.size() - bw != 0 || cpu_hold !== 1'b0)
            $display("FAIL midrst_nowrite: got writes=%0d hold=%b expected 0 0", wr_addr_q.size() - bw, cpu_hold);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SPART_LOADER_CHECKSUM_EN
        test_checksum_err();
`endif
        test_timeout();
        test_leading_bytes();
        test_full256();
        test_tx_full();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/spart_loader.md
# spart_loader

Serial boot loader between the SPART receive path and the processor's 256-word instruction/data RAM. It parses a framed byte stream from the host, assembles little-endian 16-bit words and writes them sequentially into RAM starting at word 0. The CPU is held for the duration of the frame and released once the loader answers ACK or NAK over the SPART transmit path.

## Interface
- `TIMEOUT`, default 1_000_000: inter-byte timeout in `clk` cycles; frame aborts when it is reached.
- `clk`  in  1  system clock (100 MHz domain).
- `rst`  in  1  asynchronous, active-low reset.
- `rx_valid`  in  1  one-cycle strobe, received byte available.
- `rx_data`  in  8  received byte, valid with `rx_valid`.
- `tx_full`  in  1  SPART transmit buffer full; no send allowed while high.
- `tx_send`  out  1  one-cycle send strobe.
- `tx_data`  out  8  byte to transmit, valid with `tx_send`.
- `mem_we`  out  1  RAM write enable, one cycle per word.
- `mem_addr`  out  8  RAM word address.
- `mem_wdata`  out  16  RAM write data.
- `cpu_hold`  out  1  stall request to the processor.
- `load_done`  out  1  one-cycle pulse when the frame is acknowledged.
- `load_err`  out  1  sticky error flag.

## Operation
- Frame: `0xA5`, count byte N (0 encodes 256 words), 2N data bytes (low byte first), checksum byte (XOR of N and all data bytes; present only with checksum enabled).
- States: IDLE, COUNT, LO, HI, CSUM, RESP.
- IDLE: `rx_valid` with `0xA5` -> COUNT, set `cpu_hold`, clear `load_err`, word index := 0. Any other byte is ignored.
- COUNT: latch N, seed checksum with N -> LO.
- LO: latch low byte -> HI.
- HI: on byte, register `mem_wdata = {byte, low}`, `mem_addr` = index, pulse `mem_we`; index += 1 (8-bit, wraps after 255). Last word -> CSUM, otherwise -> LO.
- CSUM: compare received byte with the running XOR. Match -> response `0x06`; mismatch -> response `0x15` and set `load_err`. Then -> RESP.
- RESP: wait for `tx_full` = 0, then pulse `tx_send` with the response, clear `cpu_hold`, pulse `load_done` (ACK only) -> IDLE.
- Timeout: an inter-byte counter clears on every `rx_valid`. In COUNT, LO, HI or CSUM, reaching `TIMEOUT` sets `load_err`, clears `cpu_hold` and returns to IDLE. No response byte is sent.
- A `rx_valid` arriving in RESP is dropped.
- Words already written before a NAK or timeout remain in RAM.

## Timing
- Reset values: all outputs 0, state IDLE, index 0, `tx_data` 0.
- `mem_we`, `mem_addr`, `mem_wdata` are registered and assert the cycle after the HI-byte `rx_valid`.
- `cpu_hold` rises the cycle after the header strobe. It falls in the same cycle as `tx_send` (or in the cycle the timeout fires).
- `tx_send` asserts only in a cycle where `tx_full` is sampled low. `tx_data` is stable during that cycle.
- Back-to-back `rx_valid` strobes on consecutive cycles must be accepted.
- Reset during a frame: immediate return to IDLE with `cpu_hold` = 0. No partial write completes after reset deasserts.

## Configuration
- `SPART_LOADER_CHECKSUM_EN` defined: CSUM state and XOR compare are compiled in, and a mismatch gives NAK.
- Not defined: no checksum byte is expected, and the last HI byte goes straight to RESP with `0x06`. `0x15` is never sent. `load_err` is set only by timeout.

## Structure
- Package `spart_loader_pkg`:
  - state enum;
  - `LDR_SYNC` = 8'hA5, `LDR_ACK` = 8'h06, `LDR_NAK` = 8'h15;
  - timeout counter width derived from `TIMEOUT`.
- Sub-module `loader_timer`: a counter with a clear input and a terminal-count output. It is instantiated once for the inter-byte timeout.

## Test plan
- Header `A5`, N=`02`, data `34 12 CD AB`, checksum `02^34^12^CD^AB`:
  - writes 0x1234 @0 and 0xABCD @1;
  - sends `0x06`;
  - `load_done` pulses once;
  - `cpu_hold` is high from the cycle after `A5` through the `tx_send` cycle.
- Same frame with a checksum byte off by one (`CSUM_EN` build) -> both words still written, `0x15` sent, `load_err` = 1, no `load_done`.
- Bytes `00 FF` in IDLE, then a valid frame -> leading bytes ignored, frame loads normally.
- N=`00` with 512 data bytes -> 256 writes at addresses 0..255, then index wraps to 0 and ACK is sent.
- `TIMEOUT` = 100, stream stops after the LO byte -> after 100 idle cycles `load_err` = 1, `cpu_hold` = 0, state IDLE, no `tx_send`.
- `tx_full` held high for 20 cycles in RESP -> `tx_send` is delayed until it drops. Reset asserted mid-HI -> all outputs 0 immediately.
